// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte sources share one UART transmitter.
// A transfer launches the UART, then waits for the busy_tx handshake (with a start timeout).
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 16,
    localparam int IDW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_parity,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_enable,
    output logic [7:0]           tx_data,
    output logic                 even_odd,
    input  logic                 busy_tx,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 tx_done,
    output logic                 timeout_err
);

    localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [CW-1:0]   counter;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  scan_idx;
    int              scan_int;
    logic [7:0]      sel_data;
    logic            sel_parity;
    logic            grant_ok;
    logic [N_REQ-1:0] win_onehot;

    // Scan starting just after the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_int  = 0;
        scan_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_int = (int'(last_grant) + k) % N_REQ;
            scan_idx = IDW'(scan_int);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_data   = 8'h00;
        sel_parity = 1'b0;
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_data      = req_data[8*i +: 8];
                sel_parity    = req_parity[i];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign grant_ok  = (state == IDLE) && !busy_tx && win_found && !rst;
    assign req_ready = grant_ok ? win_onehot : '0;
    assign active    = (state != IDLE);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_enable   <= 1'b0;
            tx_data     <= 8'h00;
            even_odd    <= 1'b0;
            grant_id    <= '0;
            last_grant  <= IDW'(N_REQ - 1);
            counter     <= '0;
            tx_done     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_enable   <= 1'b0;
            tx_done     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        tx_data    <= sel_data;
                        even_odd   <= sel_parity;
                        grant_id   <= win_idx;
                        last_grant <= win_idx;
                        tx_enable  <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    counter <= '0;
                    state   <= WAIT_START;
                end
                WAIT_START: begin
                    if (busy_tx) begin
                        state <= WAIT_DONE;
                    end else if (counter == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!busy_tx) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single frame, contention, fairness,
// back-to-back, external busy, start timeout and reset during a frame.
module tb_uart_tx_arbiter;

    logic        sys_clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_parity;
    logic [3:0]  req_ready;
    logic        tx_enable;
    logic [7:0]  tx_data;
    logic        even_odd;
    logic        busy_tx;
    logic [1:0]  grant_id;
    logic        active;
    logic        tx_done;
    logic        timeout_err;

    int vectors;
    int miscompares;

    uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(16)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_parity  (req_parity),
        .req_ready   (req_ready),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .even_odd    (even_odd),
        .busy_tx     (busy_tx),
        .grant_id    (grant_id),
        .active      (active),
        .tx_done     (tx_done),
        .timeout_err (timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_reset();
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    // Accept, launch and complete one frame; caller has just set inputs at a falling edge.
    task automatic serve_frame(input int exp_id, input logic [7:0] exp_data,
                               input logic exp_par, input logic drop_valid);
        logic [3:0] exp_ready;
        exp_ready = 4'b0001 << exp_id;
        #1;
        vectors++;
        if (req_ready !== exp_ready) begin
            $display("[TB] FAIL frame_ready id=%0d: actual %b required %b", exp_id, req_ready, exp_ready);
            miscompares++;
        end
        @(negedge sys_clk);
        vectors++;
        if (tx_enable !== 1'b1 || tx_data !== exp_data || even_odd !== exp_par
            || grant_id !== 2'(exp_id) || req_ready !== 4'b0000) begin
            $display("[TB] FAIL frame_launch id=%0d: actual en=%b data=%h par=%b gid=%0d rdy=%b required en=1 data=%h par=%b gid=%0d rdy=0000",
                     exp_id, tx_enable, tx_data, even_odd, grant_id, req_ready, exp_data, exp_par, exp_id);
            miscompares++;
        end
        if (drop_valid) req_valid[exp_id] = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (tx_enable !== 1'b0 || active !== 1'b1) begin
            $display("[TB] FAIL frame_wait_start id=%0d: actual en=%b active=%b required en=0 active=1", exp_id, tx_enable, active);
            miscompares++;
        end
        busy_tx = 1'b1;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (active !== 1'b1 || tx_done !== 1'b0 || req_ready !== 4'b0000 || tx_data !== exp_data) begin
            $display("[TB] FAIL frame_busy id=%0d: actual active=%b done=%b rdy=%b data=%h required active=1 done=0 rdy=0000 data=%h",
                     exp_id, active, tx_done, req_ready, tx_data, exp_data);
            miscompares++;
        end
        busy_tx = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (tx_done !== 1'b1 || active !== 1'b0 || timeout_err !== 1'b0) begin
            $display("[TB] FAIL frame_done id=%0d: actual done=%b active=%b terr=%b required done=1 active=0 terr=0", exp_id, tx_done, active, timeout_err);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b0000; req_data = 32'h0; req_parity = 4'b0000; busy_tx = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (tx_enable !== 1'b0 || tx_data !== 8'h00 || even_odd !== 1'b0 || req_ready !== 4'b0000
            || grant_id !== 2'd0 || active !== 1'b0 || tx_done !== 1'b0 || timeout_err !== 1'b0) begin
            $display("[TB] FAIL reset_values: actual en=%b data=%h par=%b rdy=%b gid=%0d act=%b done=%b terr=%b required all zero",
                     tx_enable, tx_data, even_odd, req_ready, grant_id, active, tx_done, timeout_err);
            miscompares++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge sys_clk);
        req_data[7:0] = 8'h5A; req_parity[0] = 1'b1; req_valid = 4'b0001;
        serve_frame(0, 8'h5A, 1'b1, 1'b1);
        @(negedge sys_clk);
        vectors++;
        if (tx_done !== 1'b0 || tx_data !== 8'h5A || even_odd !== 1'b1) begin
            $display("[TB] FAIL single_after: actual done=%b data=%h par=%b required done=0 data=5a par=1", tx_done, tx_data, even_odd);
            miscompares++;
        end
    endtask

    task automatic test_contention();
        pulse_reset();
        req_data = 32'h44332211; req_parity = 4'b1010; req_valid = 4'b1111;
        serve_frame(0, 8'h11, 1'b0, 1'b1);
        serve_frame(1, 8'h22, 1'b1, 1'b1);
        serve_frame(2, 8'h33, 1'b0, 1'b1);
        serve_frame(3, 8'h44, 1'b1, 1'b1);
    endtask

    task automatic test_fairness();
        pulse_reset();
        req_data = 32'h00C300A7; req_parity = 4'b0100; req_valid = 4'b0101;
        serve_frame(0, 8'hA7, 1'b0, 1'b0);
        serve_frame(2, 8'hC3, 1'b1, 1'b0);
        serve_frame(0, 8'hA7, 1'b0, 1'b0);
        serve_frame(2, 8'hC3, 1'b1, 1'b1);
        req_valid = 4'b0000;
    endtask

    task automatic test_back_to_back();
        @(negedge sys_clk);
        req_data[15:8] = 8'h9E; req_parity[1] = 1'b0; req_valid = 4'b0010;
        serve_frame(1, 8'h9E, 1'b0, 1'b0);
        serve_frame(1, 8'h9E, 1'b0, 1'b1);
    endtask

    task automatic test_external_busy();
        @(negedge sys_clk);
        busy_tx = 1'b1;
        req_data[7:0] = 8'h3C; req_parity[0] = 1'b0; req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0000 || active !== 1'b0) begin
                $display("[TB] FAIL ext_busy_hold cycle %0d: actual rdy=%b active=%b required rdy=0000 active=0", c, req_ready, active);
                miscompares++;
            end
            @(negedge sys_clk);
        end
        busy_tx = 1'b0;
        serve_frame(0, 8'h3C, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        @(negedge sys_clk);
        req_data[15:8] = 8'hE1; req_parity[1] = 1'b1; req_valid = 4'b0010;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            $display("[TB] FAIL timeout_ready: actual %b required 0010", req_ready);
            miscompares++;
        end
        @(negedge sys_clk);
        vectors++;
        if (tx_enable !== 1'b1 || tx_data !== 8'hE1) begin
            $display("[TB] FAIL timeout_launch: actual en=%b data=%h required en=1 data=e1", tx_enable, tx_data);
            miscompares++;
        end
        req_valid = 4'b0000;
        for (int c = 1; c <= 16; c++) begin
            @(negedge sys_clk);
            vectors++;
            if (timeout_err !== 1'b0 || active !== 1'b1) begin
                $display("[TB] FAIL timeout_waiting cycle %0d: actual terr=%b active=%b required terr=0 active=1", c, timeout_err, active);
                miscompares++;
            end
        end
        @(negedge sys_clk);
        vectors++;
        if (timeout_err !== 1'b1 || active !== 1'b0 || tx_done !== 1'b0) begin
            $display("[TB] FAIL timeout_pulse: actual terr=%b active=%b done=%b required terr=1 active=0 done=0", timeout_err, active, tx_done);
            miscompares++;
        end
        @(negedge sys_clk);
        vectors++;
        if (timeout_err !== 1'b0) begin
            $display("[TB] FAIL timeout_single_pulse: actual %b required 0", timeout_err);
            miscompares++;
        end
        req_data[23:16] = 8'h6B; req_parity[2] = 1'b0; req_valid = 4'b0100;
        serve_frame(2, 8'h6B, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge sys_clk);
        req_data[31:24] = 8'hD2; req_parity[3] = 1'b1; req_valid = 4'b1000;
        @(negedge sys_clk);
        req_valid = 4'b0000;
        @(negedge sys_clk);
        busy_tx = 1'b1;
        @(negedge sys_clk);
        vectors++;
        if (active !== 1'b1 || tx_data !== 8'hD2 || grant_id !== 2'd3) begin
            $display("[TB] FAIL rst_mid_setup: actual active=%b data=%h gid=%0d required active=1 data=d2 gid=3", active, tx_data, grant_id);
            miscompares++;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (active !== 1'b0 || tx_enable !== 1'b0 || tx_data !== 8'h00 || even_odd !== 1'b0
            || grant_id !== 2'd0 || req_ready !== 4'b0000 || tx_done !== 1'b0 || timeout_err !== 1'b0) begin
            $display("[TB] FAIL rst_mid_async: actual act=%b en=%b data=%h par=%b gid=%0d rdy=%b done=%b terr=%b required all zero",
                     active, tx_enable, tx_data, even_odd, grant_id, req_ready, tx_done, timeout_err);
            miscompares++;
        end
        busy_tx = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            vectors++;
            if (tx_done !== 1'b0 || timeout_err !== 1'b0) begin
                $display("[TB] FAIL rst_mid_no_pulse cycle %0d: actual done=%b terr=%b required 0 0", c, tx_done, timeout_err);
                miscompares++;
            end
        end
        req_data[15:8] = 8'h81; req_parity[1] = 1'b0; req_data[31:24] = 8'h7F; req_valid = 4'b1010;
        serve_frame(1, 8'h81, 1'b0, 1'b1);
        req_valid = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_back_to_back();
        test_external_busy();
        test_timeout();
        test_reset_mid_frame();
        repeat (2) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the UART transmitter.
REQ-002 Parameter START_TIMEOUT, default 16, cycles allowed for busy_tx to rise after launch.
REQ-003 Port sys_clk  input  1  system clock, all logic on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  N_REQ  per-requester byte-available flag.
REQ-006 Port req_data  input  8*N_REQ  per-requester byte; requester i at bits [8i+7:8i].
REQ-007 Port req_parity  input  N_REQ  per-requester parity select (0 even, 1 odd).
REQ-008 Port req_ready  output  N_REQ  per-requester accept strobe.
REQ-009 Port tx_enable  output  1  launch strobe to UART.
REQ-010 Port tx_data  output  8  byte to UART.
REQ-011 Port even_odd  output  1  parity select to UART.
REQ-012 Port busy_tx  input  1  UART transmitter busy.
REQ-013 Port grant_id  output  clog2(N_REQ)  index of requester currently or last served.
REQ-014 Port active  output  1  high when not in IDLE.
REQ-015 Port tx_done  output  1  one-cycle pulse when a frame completes.
REQ-016 Port timeout_err  output  1  one-cycle pulse when the UART fails to start.

Function
REQ-017 FSM states IDLE, LAUNCH, WAIT_START, WAIT_DONE; exactly one state per cycle.
REQ-018 IDLE: grant only when busy_tx=0 and any req_valid=1; otherwise stay in IDLE.
REQ-019 Arbitration is round-robin; search starts at last_grant+1 mod N_REQ and takes the first valid index.
REQ-020 req_ready is combinational: one-hot on the winner only while in IDLE with a grant; all zeros otherwise.
REQ-021 Transfer occurs on a cycle where req_valid[i]=1 and req_ready[i]=1; the arbiter then latches req_data slice into tx_data, req_parity[i] into even_odd, i into grant_id and last_grant, and moves to LAUNCH.
REQ-022 Requesters hold valid, data and parity stable until accepted; dropping valid before accept withdraws the request with no side effect.
REQ-023 LAUNCH: tx_enable=1 for exactly one cycle; next state WAIT_START; start counter cleared.
REQ-024 tx_data and even_odd hold their latched values from acceptance until the next acceptance.
REQ-025 WAIT_START: busy_tx=1 -> WAIT_DONE; else counter increments; when counter = START_TIMEOUT-1 and busy_tx=0 -> timeout_err pulse, go IDLE.
REQ-026 WAIT_DONE: busy_tx=0 -> tx_done pulse, go IDLE; no timeout in this state.
REQ-027 Latency: accept in cycle T, tx_enable high in cycle T+1; earliest next accept is the cycle after busy_tx falls.
REQ-028 Back-to-back: a requester still valid after its own grant gets the next slot only if no other requester is valid.
REQ-029 tx_done and timeout_err never assert in the same cycle.
REQ-030 active = (state != IDLE).

Reset
REQ-031 On rst=1 asynchronously: state IDLE, tx_enable 0, tx_data 0x00, even_odd 0, req_ready 0, grant_id 0, tx_done 0, timeout_err 0, counter 0, last_grant N_REQ-1.
REQ-032 Reset mid-frame abandons the transfer with no tx_done or timeout_err; first grant after reset goes to the lowest valid index.

Verification
REQ-033 Single request: req_valid=0001, data0=0x5A, parity0=1 -> req_ready=0001 one cycle, tx_enable next cycle, tx_data=0x5A, even_odd=1; UART busy rise/fall -> one tx_done pulse.
REQ-034 Contention: all four valid, each with a distinct byte -> grants in order 0,1,2,3; each tx_enable waits for busy_tx fall of the previous frame.
REQ-035 Fairness: req0 and req2 continuously valid -> grants alternate 0,2,0,2.
REQ-036 Timeout: busy_tx held 0 after launch -> timeout_err pulse on WAIT_START cycle 16; returns to IDLE; next request is served normally.
REQ-037 External busy: busy_tx=1 while in IDLE with req_valid=0001 -> req_ready stays 0 until busy_tx=0.
REQ-038 Reset in WAIT_DONE: assert rst -> all outputs at reset values immediately; no tx_done pulse.
